scan_sequencer: RTL and testbench

- Parametrised successor of the scan data path. Autonomously sequences one LiDAR scan from scan memory into the Bresenham ray tracer. Replaces externally driven address/position/start strobes with an internal FSM.
- Optionally clears the occupancy grid before the first beam.
- Owns the occupancy index mux between ray-trace indices and display indices.
- Sits between scan_memory, bresenham and occupancy. The top-level control unit only issues `start` and observes `done`.

---
 rtl/scan_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_scan_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_sequencer.sv
// Scan sequencer: walks one LiDAR scan out of scan memory and feeds each beam
// to the Bresenham ray tracer. It can clear the occupancy grid first, and it
// owns the occupancy index mux (ray-trace indices while tracing, display
// indices otherwise).
// Optional build macro SCAN_SKIP_ZERO_BEAM_EN: beams whose magnitude is zero
// are skipped instead of traced.
module scan_sequencer #(
  parameter int unsigned NUM_BEAMS  = 720,
  parameter int unsigned WORD_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned X_WIDTH    = 8,
  parameter int unsigned Y_WIDTH    = 7
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    clear_grid,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   beam_count,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  input  logic [WORD_WIDTH-1:0]   mem_data,
  output logic                    bres_start,
  output logic [WORD_WIDTH/2-1:0] bres_magnitude,
  output logic [WORD_WIDTH/2-1:0] bres_angle,
  output logic [WORD_WIDTH/2-1:0] sensor_x,
  output logic [WORD_WIDTH/2-1:0] sensor_y,
  input  logic                    bres_busy,
  input  logic [X_WIDTH-1:0]      bres_x,
  input  logic [Y_WIDTH-1:0]      bres_y,
  input  logic [X_WIDTH-1:0]      disp_x,
  input  logic [Y_WIDTH-1:0]      disp_y,
  output logic [X_WIDTH-1:0]      occ_x,
  output logic [Y_WIDTH-1:0]      occ_y,
  output logic                    occ_zero,
  input  logic                    occ_busy
);

  localparam int unsigned HalfWidth = WORD_WIDTH / 2;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NUM_BEAMS);

  typedef enum logic [3:0] {
    StIdle,
    StZero,
    StZeroWait,
    StPosRd,
    StPosLatch,
    StBeamRd,
    StBeamLatch,
    StTrace,
    StTraceWait,
    StFinish
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   count_q, count_d;
  logic [HalfWidth-1:0]    mag_q, mag_d;
  logic [HalfWidth-1:0]    ang_q, ang_d;
  logic [HalfWidth-1:0]    sx_q, sx_d;
  logic [HalfWidth-1:0]    sy_q, sy_d;
  // High in the first cycle of a wait state, where the peer's busy flag is
  // not yet trustworthy.
  logic                    first_q, first_d;

  logic [HalfWidth-1:0]    data_hi, data_lo;
  logic                    skip_beam;
  logic                    last_beam;
  logic                    in_trace;

  assign data_hi   = mem_data[WORD_WIDTH-1 -: HalfWidth];
  assign data_lo   = mem_data[HalfWidth-1:0];
  assign last_beam = (addr_q == LastAddr);

`ifdef SCAN_SKIP_ZERO_BEAM_EN
  assign skip_beam = (data_hi == '0);
`else
  assign skip_beam = 1'b0;
`endif

  // State and datapath registers; reset aborts any scan in progress.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      count_q <= '0;
      mag_q   <= '0;
      ang_q   <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      mag_q   <= mag_d;
      ang_q   <= ang_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      first_q <= first_d;
    end
  end

  // Next-state logic and strobes for the scan FSM.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    mag_d      = mag_q;
    ang_d      = ang_q;
    sx_d       = sx_q;
    sy_d       = sy_q;
    first_d    = 1'b0;
    done       = 1'b0;
    bres_start = 1'b0;
    occ_zero   = 1'b0;

    unique case (state_q)
      StIdle: begin
        addr_d = '0;
        if (start) begin
          count_d = '0;
          state_d = clear_grid ? StZero : StPosRd;
        end
      end
      StZero: begin
        occ_zero = 1'b1;
        first_d  = 1'b1;
        state_d  = StZeroWait;
      end
      StZeroWait: begin
        if (!first_q && !occ_busy) state_d = StPosRd;
      end
      StPosRd: begin
        addr_d  = '0;
        state_d = StPosLatch;
      end
      StPosLatch: begin
        sx_d    = data_hi;
        sy_d    = data_lo;
        addr_d  = ADDR_WIDTH'(1);
        state_d = StBeamRd;
      end
      StBeamRd: begin
        state_d = StBeamLatch;
      end
      StBeamLatch: begin
        mag_d = data_hi;
        ang_d = data_lo;
        if (!skip_beam) begin
          state_d = StTrace;
        end else if (last_beam) begin
          state_d = StFinish;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = StBeamRd;
        end
      end
      StTrace: begin
        if (!bres_busy && !occ_busy) begin
          bres_start = 1'b1;
          count_d    = count_q + ADDR_WIDTH'(1);
          first_d    = 1'b1;
          state_d    = StTraceWait;
        end
      end
      StTraceWait: begin
        if (!first_q && !bres_busy) begin
          if (last_beam) begin
            state_d = StFinish;
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = StBeamRd;
          end
        end
      end
      StFinish: begin
        done    = 1'b1;
        addr_d  = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Occupancy index mux: tracer owns the grid only while a beam is traced.
  always_comb begin
    in_trace = (state_q == StTrace) || (state_q == StTraceWait);
    occ_x    = in_trace ? bres_x : disp_x;
    occ_y    = in_trace ? bres_y : disp_y;
  end

  assign busy           = (state_q != StIdle);
  assign beam_count     = count_q;
  assign mem_address    = addr_q;
  assign bres_magnitude = mag_q;
  assign bres_angle     = ang_q;
  assign sensor_x       = sx_q;
  assign sensor_y       = sy_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer with 4 beams: memory, Bresenham and
// occupancy are small behavioural models; expected beams are queued at start.
module tb_scan_sequencer;

  localparam int unsigned NB = 4;
  localparam int unsigned AW = 13;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start, clear_grid;
  logic          busy, done, bres_start, occ_zero;
  logic [AW-1:0] beam_count, mem_address;
  logic [63:0]   mem_data;
  logic [31:0]   bres_magnitude, bres_angle, sensor_x, sensor_y;
  logic          bres_busy, occ_busy;
  logic [7:0]    bres_x, disp_x, occ_x;
  logic [6:0]    bres_y, disp_y, occ_y;

  logic [63:0]   mem [16];
  int            bres_cnt = 0;
  int            zero_cnt = 0;
  logic          hold_busy = 1'b0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   mag;
    logic [31:0]   ang;
    logic [31:0]   sx;
    logic [31:0]   sy;
  } beam_t;

  typedef struct packed {
    logic [AW-1:0] count;
    logic [7:0]    zeros;
  } done_t;

  beam_t exp_beam [$];
  done_t exp_done [$];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   zero_seen = 0;
  logic tw_check = 1'b0;

  scan_sequencer #(
    .NUM_BEAMS (NB),
    .WORD_WIDTH(64),
    .ADDR_WIDTH(AW),
    .X_WIDTH   (8),
    .Y_WIDTH   (7)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .clear_grid    (clear_grid),
    .busy          (busy),
    .done          (done),
    .beam_count    (beam_count),
    .mem_address   (mem_address),
    .mem_data      (mem_data),
    .bres_start    (bres_start),
    .bres_magnitude(bres_magnitude),
    .bres_angle    (bres_angle),
    .sensor_x      (sensor_x),
    .sensor_y      (sensor_y),
    .bres_busy     (bres_busy),
    .bres_x        (bres_x),
    .bres_y        (bres_y),
    .disp_x        (disp_x),
    .disp_y        (disp_y),
    .occ_x         (occ_x),
    .occ_y         (occ_y),
    .occ_zero      (occ_zero),
    .occ_busy      (occ_busy)
  );

  always #5 clock = ~clock;

  // Synchronous scan memory, one cycle read latency.
  always @(posedge clock) mem_data <= mem[mem_address[3:0]];

  // Bresenham busy for 3 cycles after each start; occupancy 10 after zero.
  always @(posedge clock) begin
    if (bres_start) bres_cnt <= 3;
    else if (bres_cnt > 0) bres_cnt <= bres_cnt - 1;
    if (occ_zero) zero_cnt <= 10;
    else if (zero_cnt > 0) zero_cnt <= zero_cnt - 1;
  end
  assign bres_busy = (bres_cnt != 0);
  assign occ_busy  = (zero_cnt != 0) || hold_busy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic skip_of(input logic [31:0] m);
`ifdef SCAN_SKIP_ZERO_BEAM_EN
    return (m == 32'h0);
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: pops expectations whenever the DUT presents a strobe.
  always @(negedge clock) begin
    if (reset_n) begin
      if (tw_check) begin
        check("occ_x_trace_wait", {56'h0, occ_x}, 64'h55);
        check("occ_y_trace_wait", {57'h0, occ_y}, 64'h2A);
        tw_check = 1'b0;
      end
      if (occ_zero) begin
        zero_seen++;
        check("occ_zero_addr", {51'h0, mem_address}, 64'h0);
      end
      if (bres_start) begin
        beam_t b;
        check("bres_start_peers_idle", {62'h0, occ_busy, bres_busy}, 64'h0);
        check("busy_in_trace", {63'h0, busy}, 64'h1);
        if (exp_beam.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_bres_start: got a pulse at address %0d, required none",
                   mem_address);
        end else begin
          b = exp_beam.pop_front();
          check("beam_address", {51'h0, mem_address}, {51'h0, b.addr});
          check("beam_magnitude", {32'h0, bres_magnitude}, {32'h0, b.mag});
          check("beam_angle", {32'h0, bres_angle}, {32'h0, b.ang});
          check("sensor_x", {32'h0, sensor_x}, {32'h0, b.sx});
          check("sensor_y", {32'h0, sensor_y}, {32'h0, b.sy});
        end
        tw_check = 1'b1;
      end
      if (done) begin
        done_t d;
        if (exp_done.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_done: got a done pulse, required none");
        end else begin
          d = exp_done.pop_front();
          check("beam_count_at_done", {51'h0, beam_count}, {51'h0, d.count});
          check("occ_zero_pulses", 64'(zero_seen), {56'h0, d.zeros});
        end
        zero_seen = 0;
      end
    end
  end

  task automatic load_scan(input logic [63:0] pos, input logic [31:0] mag2);
    mem[0] = pos;
    for (int i = 1; i <= NB; i++) mem[i] = {32'(i * 16 + 3), 32'(32'h100 + i)};
    mem[2][63:32] = mag2;
  endtask

  // Queue expectations from the bench's own memory image, then pulse start.
  task automatic start_scan(input logic clr);
    int traced = 0;
    for (int i = 1; i <= NB; i++) begin
      if (!skip_of(mem[i][63:32])) begin
        exp_beam.push_back({AW'(i), mem[i][63:32], mem[i][31:0], mem[0][63:32], mem[0][31:0]});
        traced++;
      end
    end
    exp_done.push_back({AW'(traced), clr ? 8'd1 : 8'd0});
    @(posedge clock); #1;
    clear_grid = clr;
    start      = 1'b1;
    @(posedge clock); #1;
    start      = 1'b0;
    clear_grid = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (exp_done.size() != 0 && k < 400) begin
      @(posedge clock);
      k++;
    end
    check("scan_completed", 64'(exp_done.size()), 64'h0);
    check("beams_consumed", 64'(exp_beam.size()), 64'h0);
    @(negedge clock);
    check("idle_busy", {63'h0, busy}, 64'h0);
    check("idle_address", {51'h0, mem_address}, 64'h0);
  endtask

  task automatic wait_bres_start();
    int k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!bres_start && k < 200);
    check("bres_start_seen", {63'h0, bres_start}, 64'h1);
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b1;
    clear_grid = 1'b0;
    disp_x     = 8'hAA;
    disp_y     = 7'h15;
    bres_x     = 8'h55;
    bres_y     = 7'h2A;
    for (int i = 0; i < 16; i++) mem[i] = 64'h0;

    // Reset with start held.
    repeat (3) @(negedge clock);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    check("rst_bres_start", {63'h0, bres_start}, 64'h0);
    check("rst_occ_zero", {63'h0, occ_zero}, 64'h0);
    check("rst_address", {51'h0, mem_address}, 64'h0);
    check("rst_beam_count", {51'h0, beam_count}, 64'h0);
    check("rst_magnitude", {32'h0, bres_magnitude}, 64'h0);
    check("rst_angle", {32'h0, bres_angle}, 64'h0);
    check("rst_sensor", {sensor_x, sensor_y}, 64'h0);
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("idle_occ_x", {56'h0, occ_x}, 64'hAA);
    check("idle_occ_y", {57'h0, occ_y}, 64'h15);

    // Plain scan.
    load_scan({32'h10, 32'h20}, 32'h23);
    start_scan(1'b0);
    wait_done();

    // Scan with grid clear; occupancy busy 10 cycles.
    load_scan({32'h30, 32'h40}, 32'h77);
    start_scan(1'b1);
    wait_done();

    // Zero-magnitude beam 2, occupancy held busy over its trace, stray start.
    load_scan({32'h50, 32'h60}, 32'h0);
    start_scan(1'b0);
    wait_bres_start();
    @(posedge clock); #1;
    repeat (5) @(posedge clock);
    #1;
    hold_busy = 1'b1;
    start     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("held_no_bres_start", {63'h0, bres_start}, 64'h0);
      @(posedge clock); #1;
      start = 1'b0;
    end
    hold_busy = 1'b0;
    wait_done();

    // Reset during TRACE_WAIT aborts without done.
    load_scan({32'h70, 32'h80}, 32'h44);
    start_scan(1'b0);
    wait_bres_start();
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    check("abort_busy", {63'h0, busy}, 64'h0);
    check("abort_address", {51'h0, mem_address}, 64'h0);
    check("abort_beam_count", {51'h0, beam_count}, 64'h0);
    check("abort_magnitude", {32'h0, bres_magnitude}, 64'h0);
    exp_beam.delete();
    exp_done.delete();
    tw_check  = 1'b0;
    zero_seen = 0;
    repeat (3) begin
      @(negedge clock);
      check("abort_no_done", {63'h0, done}, 64'h0);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Recovery scan after abort.
    load_scan({32'h11, 32'h22}, 32'h99);
    start_scan(1'b0);
    wait_done();
    check("final_occ_x", {56'h0, occ_x}, 64'hAA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
